ff_array_requester: RTL

//  Initiator side of the flip-flop array access interface (din/addr/wr/rd -> dout/error).

---
 rtl/ff_array_pkg.sv | 21 ++
 rtl/ff_array_requester.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ff_array_pkg.sv
// Shared types and default widths for the flip-flop array requester.
// state_e is the requester FSM; req_t is one latched array request.
package ff_array_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } req_t;

endpackage

// File: rtl/ff_array_requester.sv
// Initiator for the flip-flop array: one request -> one arr_wr/arr_rd pulse -> one response.
// Ports: req_* request channel, rsp_* response channel, arr_* array side, proto_err/wr_cnt/rd_cnt status.
module ff_array_requester
    import ff_array_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_unwr,
    output logic [DATA_W-1:0] arr_din,
    output logic [ADDR_W-1:0] arr_addr,
    output logic              arr_wr,
    output logic              arr_rd,
    input  logic [DATA_W-1:0] arr_dout,
    input  logic              arr_error,
    output logic              proto_err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] RD_LAT = 2'(READ_LAT);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              wr_l_q, wr_l_d;
    logic [ADDR_W-1:0] addr_l_q, addr_l_d;
    logic [1:0]        wait_q, wait_d;
    logic [DEPTH-1:0]  shadow_q, shadow_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_unwr_q, rsp_unwr_d;
    logic [DATA_W-1:0] arr_din_q, arr_din_d;
    logic [ADDR_W-1:0] arr_addr_q, arr_addr_d;
    logic              arr_wr_q, arr_wr_d;
    logic              arr_rd_q, arr_rd_d;
    logic              proto_err_q, proto_err_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    // An entry never written since reset reads as zero and is flagged,
    // regardless of what the array drives on dout.
    logic              hit;
    assign hit = shadow_q[addr_l_q];

    always_comb begin
        state_d     = state_q;
        wr_l_d      = wr_l_q;
        addr_l_d    = addr_l_q;
        wait_d      = wait_q;
        shadow_d    = shadow_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_unwr_d  = rsp_unwr_q;
        arr_din_d   = arr_din_q;
        arr_addr_d  = arr_addr_q;
        arr_wr_d    = 1'b0;
        arr_rd_d    = 1'b0;
        proto_err_d = proto_err_q | arr_error;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_l_d     = req_wr;
                    addr_l_d   = req_addr;
                    arr_addr_d = req_addr;
                    arr_din_d  = req_wr ? req_data : '0;
                    arr_wr_d   = req_wr;
                    arr_rd_d   = ~req_wr;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_l_q) begin
                    shadow_d[addr_l_q] = 1'b1;
                    rsp_valid_d        = 1'b1;
                    rsp_data_d         = '0;
                    rsp_unwr_d         = 1'b0;
                    state_d            = RESP;
                end else if (READ_LAT == 0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = hit ? arr_dout : '0;
                    rsp_unwr_d  = ~hit;
                    state_d     = RESP;
                end else begin
                    wait_d  = 2'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == RD_LAT) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = hit ? arr_dout : '0;
                    rsp_unwr_d  = ~hit;
                    state_d     = RESP;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (wr_l_q) begin
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end else begin
                        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            wr_l_q      <= 1'b0;
            addr_l_q    <= '0;
            wait_q      <= '0;
            shadow_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_unwr_q  <= 1'b0;
            arr_din_q   <= '0;
            arr_addr_q  <= '0;
            arr_wr_q    <= 1'b0;
            arr_rd_q    <= 1'b0;
            proto_err_q <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            wr_l_q      <= wr_l_d;
            addr_l_q    <= addr_l_d;
            wait_q      <= wait_d;
            shadow_q    <= shadow_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_unwr_q  <= rsp_unwr_d;
            arr_din_q   <= arr_din_d;
            arr_addr_q  <= arr_addr_d;
            arr_wr_q    <= arr_wr_d;
            arr_rd_q    <= arr_rd_d;
            proto_err_q <= proto_err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_unwr  = rsp_unwr_q;
    assign arr_din   = arr_din_q;
    assign arr_addr  = arr_addr_q;
    assign arr_wr    = arr_wr_q;
    assign arr_rd    = arr_rd_q;
    assign proto_err = proto_err_q;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

endmodule
